// File: rtl/ones_frame_acc_if.sv
// Handshake bundle between the popcount producer, the frame accumulator and the result consumer.
interface ones_frame_acc_if #(
    parameter int unsigned SUM_W  = 8,
    parameter int unsigned WCNT_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_cnt;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_sum;
    logic [WCNT_W-1:0] out_words;
    logic              out_major;
    logic              out_ovf;
    logic              out_err;

    // Environment side: drives words in and takes results out
    modport master (
        output in_valid, in_cnt, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_words, out_major, out_ovf, out_err
    );

    // Accumulator side
    modport slave (
        input  in_valid, in_cnt, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_words, out_major, out_ovf, out_err
    );
endinterface

// File: rtl/ones_frame_acc.sv
// Accumulates per-word popcounts over a frame and holds the frame summary until taken.
module ones_frame_acc #(
    parameter int unsigned SUM_W  = 8,
    parameter int unsigned WCNT_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    ones_frame_acc_if.slave   bus
);
    // Compare width wide enough for sum and 3*words without truncation
    localparam int unsigned MW = ((SUM_W > WCNT_W + 2) ? SUM_W : WCNT_W + 2) + 1;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [SUM_W-1:0]  sum_q;
    logic [WCNT_W-1:0] words_q;
    logic              ovf_q;
    logic              err_q;

    logic              accept;
    logic              take;
    logic [2:0]        cnt_clamp;
    logic [SUM_W:0]    sum_ext;
    logic [WCNT_W:0]   words_ext;
    logic [SUM_W-1:0]  sum_nxt;
    logic [WCNT_W-1:0] words_nxt;
    logic              ovf_nxt;
    logic              err_nxt;
    logic [MW-1:0]     words_x3;
    logic              major_nxt;

    assign accept = bus.in_valid & (state_q == ST_ACC);
    assign take   = bus.out_ready & (state_q == ST_HOLD);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: close the frame on the last accepted word, reopen on result take
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:  if (accept && bus.in_last) state_d = ST_HOLD;
            ST_HOLD: if (take)                  state_d = ST_ACC;
            default: state_d = ST_ACC;
        endcase
    end

    // Handshake outputs decoded from state only
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            ST_ACC:  bus.in_ready  = 1'b1;
            ST_HOLD: bus.out_valid = 1'b1;
            default: bus.in_ready  = 1'b0;
        endcase
    end

    // Saturating next values of the accumulators and the frame flags
    always_comb begin
        cnt_clamp = (bus.in_cnt > 3'd6) ? 3'd6 : bus.in_cnt;
        sum_ext   = {1'b0, sum_q} + (SUM_W + 1)'(cnt_clamp);
        words_ext = {1'b0, words_q} + (WCNT_W + 1)'(1);
        sum_nxt   = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
        words_nxt = words_ext[WCNT_W] ? '1 : words_ext[WCNT_W-1:0];
        ovf_nxt   = ovf_q | sum_ext[SUM_W] | words_ext[WCNT_W];
        err_nxt   = err_q | (bus.in_cnt == 3'd7);
        words_x3  = (MW'(words_nxt) << 1) + MW'(words_nxt);
        major_nxt = MW'(sum_nxt) > words_x3;
    end

    // Accumulators: add on accept, clear once the result has been taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            words_q <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            sum_q   <= sum_nxt;
            words_q <= words_nxt;
            ovf_q   <= ovf_nxt;
            err_q   <= err_nxt;
        end else if (take) begin
            sum_q   <= '0;
            words_q <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end
    end

    // Result registers: loaded with the final word included, kept until the next frame ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_sum   <= '0;
            bus.out_words <= '0;
            bus.out_major <= 1'b0;
            bus.out_ovf   <= 1'b0;
            bus.out_err   <= 1'b0;
        end else if (accept && bus.in_last) begin
            bus.out_sum   <= sum_nxt;
            bus.out_words <= words_nxt;
            bus.out_major <= major_nxt;
            bus.out_ovf   <= ovf_nxt;
            bus.out_err   <= err_nxt;
        end
    end
endmodule

// File: tb/tb_ones_frame_acc.sv
// Directed bench for ones_frame_acc: hand-computed frame results, backpressure and reset cases.
module tb_ones_frame_acc;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    ones_frame_acc_if #(.SUM_W(8), .WCNT_W(6)) bus ();

    ones_frame_acc #(.SUM_W(8), .WCNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge with in_ready high; presents one word for the next rising edge
    task automatic send(input logic [2:0] c, input logic last);
        bus.in_valid = 1'b1;
        bus.in_cnt   = c;
        bus.in_last  = last;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_cnt   = 3'd0;
    endtask

    task automatic check_result(input string tag, input int s, input int w, input int maj,
                                input int ovf, input int err);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, ".sum"},   32'(bus.out_sum), 32'(s));
        check({tag, ".words"}, 32'(bus.out_words), 32'(w));
        check({tag, ".major"}, 32'(bus.out_major), 32'(maj));
        check({tag, ".ovf"},   32'(bus.out_ovf), 32'(ovf));
        check({tag, ".err"},   32'(bus.out_err), 32'(err));
    endtask

    task automatic take(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, ".take_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, ".take_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_cnt    = 3'd0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset then idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.ready", 32'(bus.in_ready), 32'd1);
        check("rst.valid", 32'(bus.out_valid), 32'd0);
        check("rst.sum",   32'(bus.out_sum), 32'd0);
        check("rst.words", 32'(bus.out_words), 32'd0);
        check("rst.major", 32'(bus.out_major), 32'd0);
        check("rst.ovf",   32'(bus.out_ovf), 32'd0);
        check("rst.err",   32'(bus.out_err), 32'd0);

        // Basic frame 3,6,0,2 -> 11 ones in 4 words, 11 <= 12 so no majority
        send(3'd3, 1'b0);
        send(3'd6, 1'b0);
        send(3'd0, 1'b0);
        send(3'd2, 1'b1);
        check_result("basic", 11, 4, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("basic.hold_ready", 32'(bus.in_ready), 32'd0);
            check("basic.hold_valid", 32'(bus.out_valid), 32'd1);
            check("basic.hold_sum",   32'(bus.out_sum), 32'd11);
        end
        take("basic");
        check("basic.kept_sum", 32'(bus.out_sum), 32'd11);

        // Single-word frames: 4 > 3 is a majority, 3 > 3 is not
        send(3'd4, 1'b1);
        check_result("single4", 4, 1, 1, 0, 0);
        take("single4");
        send(3'd3, 1'b1);
        check_result("single3", 3, 1, 0, 0, 0);
        take("single3");

        // Sum saturation: 45 x 6 = 270 -> 255
        for (int i = 0; i < 44; i++) send(3'd6, 1'b0);
        send(3'd6, 1'b1);
        check_result("satsum", 255, 45, 1, 1, 0);
        take("satsum");

        // Word-count saturation: 70 words -> 63
        for (int i = 0; i < 69; i++) send(3'd0, 1'b0);
        send(3'd0, 1'b1);
        check_result("satwords", 0, 63, 0, 1, 0);
        take("satwords");

        // Next frame starts with the overflow flag cleared
        send(3'd1, 1'b1);
        check_result("ovfclr", 1, 1, 0, 0, 0);
        take("ovfclr");

        // Illegal count 7 clamps to 6: 6+1 = 7 over 2 words, 7 > 6 majority
        send(3'd7, 1'b0);
        send(3'd1, 1'b1);
        check_result("illegal", 7, 2, 1, 0, 1);
        // Words offered during HOLD must not be counted
        bus.in_valid = 1'b1;
        bus.in_cnt   = 3'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_ignore.ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.in_cnt   = 3'd0;
        take("illegal");
        send(3'd2, 1'b1);
        check_result("after_hold", 2, 1, 0, 0, 0);
        take("after_hold");

        // Reset between edges in the middle of a frame discards the partial sum
        send(3'd5, 1'b0);
        send(3'd5, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.valid", 32'(bus.out_valid), 32'd0);
        check("midrst.sum",   32'(bus.out_sum), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst.ready", 32'(bus.in_ready), 32'd1);
        check("midrst.valid2", 32'(bus.out_valid), 32'd0);
        send(3'd1, 1'b1);
        check_result("midrst", 1, 1, 0, 0, 0);
        take("midrst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/ones_frame_acc.md
# ones_frame_acc

Downstream stage of the 6-bit ones-counter. It accepts one 3-bit popcount per cycle (0..6) over a valid/ready handshake and accumulates the counts across a frame delimited by `in_last`. At frame end it presents the total ones, the word count, a majority flag and error flags on a valid/ready output port. It holds the result until the consumer takes it.

## Interface
- `SUM_W`, default 8: width of the ones accumulator.
- `WCNT_W`, default 6: width of the word counter.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset; one clock domain.
- `in_valid` input 1: `in_cnt`/`in_last` valid this cycle.
- `in_ready` output 1: block accepts a word this cycle.
- `in_cnt` input 3: popcount of one 6-bit word; legal range 0..6.
- `in_last` input 1: qualifies the final word of a frame.
- `out_valid` output 1: frame result available.
- `out_ready` input 1: consumer takes the result.
- `out_sum` output SUM_W: total ones in the frame (saturating).
- `out_words` output WCNT_W: words in the frame (saturating).
- `out_major` output 1: ones strictly exceed half of all bits, i.e. sum > 3*words.
- `out_ovf` output 1: `out_sum` or `out_words` saturated during the frame.
- `out_err` output 1: at least one `in_cnt` value > 6 was received.

## Operation
- FSM has two states: ACC and HOLD. Reset state is ACC.
- In ACC, `in_ready` is 1.
  - Accept condition is `in_valid & in_ready`.
  - On accept, `sum <= sat(sum + c)` and `words <= sat(words + 1)`.
  - `c` is `in_cnt` clamped to 6. If `in_cnt` is 7, set the sticky `err` flag.
  - Saturation: if a result exceeds 2^W-1, it holds at all-ones and sets the sticky `ovf` flag.
  - An accept with `in_last=1` registers the final values (including that word) to the outputs and moves to HOLD.
- In HOLD, `in_ready` is 0 and `out_valid` is 1.
  - Outputs are stable until `out_valid & out_ready`.
  - On that handshake: return to ACC and clear `sum`, `words`, `ovf`, `err`.
- `out_major` is computed from final `out_sum` and `out_words` with width max(SUM_W, WCNT_W+2)+1, so no truncation. It is registered with the other outputs.
- `in_valid` without `in_last` in ACC simply keeps accumulating. A frame has no maximum length other than saturation.
- `in_valid` while in HOLD is ignored. The producer must hold its data until `in_ready`.
- Single-word frame (`in_last` on the first accept) is legal.

## Timing
- Reset values: `in_ready`=1 (state ACC), `out_valid`=0, `out_sum`=0, `out_words`=0, `out_major`=0, `out_ovf`=0, `out_err`=0. Internal accumulators are 0.
- Reset asserted mid-frame or in HOLD discards everything immediately (asynchronous). No result is emitted.
- Throughput: one word per cycle in ACC.
- Latency: `out_valid` rises in the cycle after the `in_last` accept edge.
- Output handshake in cycle N returns to ACC. `in_ready`=1 from cycle N+1. Minimum frame gap is therefore 1 cycle. No same-cycle output take and input accept.
- Outputs keep their last values after the handshake until the next frame completes. `out_valid` is 0 after the handshake.
- `in_ready` and `out_valid` are decoded from state only, with no combinational path from `out_ready`/`in_valid`.

## Test plan
- **Reset then idle:** hold `rst_n`=0 for 3 cycles, release, no input -> `in_ready`=1, `out_valid`=0, all outputs 0.
- **Basic frame:** `in_cnt` 3,6,0,2 on consecutive cycles, `in_last` on 2 -> next cycle `out_valid`=1, `out_sum`=11, `out_words`=4, `out_major`=0 (11 ≤ 12), `ovf`=0, `err`=0. With `out_ready` low for 5 cycles, `in_ready`=0 and outputs are stable; the first `out_ready` cycle is followed by `in_ready`=1.
- **Majority and single-word frame:** `in_cnt`=4 with `in_last` -> `out_sum`=4, `out_words`=1, `out_major`=1. Then `in_cnt`=3 with `in_last` -> `out_major`=0.
- **Saturation:** 45 words of `in_cnt`=6 (270 > 255) -> `out_sum`=255, `out_words`=45, `out_ovf`=1. Then 70 words of 0 -> `out_words`=63, `out_ovf`=1. The following frame shows `ovf` cleared.
- **Illegal count and backpressure:** `in_cnt` 7,1 with `in_last` -> `out_sum`=7 (6+1), `out_err`=1. `in_valid` asserted during HOLD is not counted toward the next frame.
- **Reset mid-frame:** accept 5,5, pulse `rst_n` low asynchronously (between edges), then send 1 with `in_last` -> `out_sum`=1, `out_words`=1, and no earlier `out_valid` pulse.
